video_stream_crc_monitor: RTL and testbench
===========================================

VIDEO_STREAM_CRC_MONITOR -- requirements
Module: video_stream_crc_monitor

Interface
REQ-001 Parameter NUM_CH, default 3: number of colour channels in each beat.
REQ-002 Parameter CH_W, default 8: bits per channel.
REQ-003 Parameter DIM_W, default 16: width of the dimension and position counters.
REQ-004 Derived DATA_W = NUM_CH*CH_W; channel k occupies tdata[k*CH_W +: CH_W].
REQ-005 Port list:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_W  pixel data.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  in  1  sink ready; the block observes it and never drives it.
- s_axis_tuser  in  1  start of frame, on the first beat of a frame.
- s_axis_tlast  in  1  end of line.
- cfg_width  in  DIM_W  expected pixels per line; must be at least 1.
- cfg_height  in  DIM_W  expected lines per frame; must be at least 1.
- cfg_golden  in  NUM_CH*32  expected per-channel CRC.
- cfg_golden_en  in  1  enables the golden compare.
- clear  in  1  one-cycle pulse clearing counters and sticky flags.
- crc_last  out  NUM_CH*32  per-channel CRC of the last complete frame.
- crc_valid  out  1  one-cycle pulse when crc_last updates.
- frame_count  out  32  number of complete frames.
- line_count  out  DIM_W  current line index within the frame.
- pixel_in_line  out  DIM_W  current pixel index within the line.
- err_flags  out  4  sticky flags: [0] short line, [1] long line, [2] early SOF, [3] golden mismatch.
- irq  out  1  one-cycle pulse on frame completion or on a new error.

Function
REQ-006 A beat is accepted only when s_axis_tvalid and s_axis_tready are both high; nothing changes on any other cycle.
REQ-007 States are IDLE and ACTIVE; IDLE is entered on reset.
REQ-008 In IDLE, accepted beats with tuser=0 are ignored; an accepted beat with tuser=1 moves the block to ACTIVE and is processed as pixel (0,0).
REQ-009 CRC per channel: reflected CRC-32 (poly 0x04C11DB7), init 0xFFFFFFFF, data LSB first, final XOR 0xFFFFFFFF. The CRC advances by CH_W bits per accepted beat, one beat per cycle, with no stall.
REQ-010 An accepted beat with tuser=1 always reinitialises all channel CRCs before folding that beat in.
REQ-011 In ACTIVE, an accepted beat with tuser=1 sets err_flags[2] and restarts the frame at (0,0); crc_last is not updated.
REQ-012 On each accepted beat, pixel_in_line increments. If tlast=1, pixel_in_line returns to 0 and line_count increments.
REQ-013 tlast=1 with pixel_in_line+1 < cfg_width sets err_flags[0]; the line is still closed.
REQ-014 tlast=0 with pixel_in_line+1 >= cfg_width sets err_flags[1]; the counter saturates at all-ones.
REQ-015 tlast=1 on line cfg_height-1 completes the frame, and the following registered updates occur on the next cycle:
- crc_last takes the finalised CRCs.
- crc_valid pulses.
- frame_count increments, wrapping from 0xFFFFFFFF to 0.
- line_count and pixel_in_line are 0.
- The state goes to IDLE.
REQ-016 A beat arriving after frame completion without tuser=1 is ignored per REQ-008.
REQ-017 With cfg_golden_en=1, a completed frame whose any channel CRC differs from cfg_golden sets err_flags[3], in the same cycle as crc_valid.
REQ-018 irq pulses for one cycle on crc_valid, or on any err_flags bit going from 0 to 1. Simultaneous causes produce a single pulse.
REQ-019 clear zeroes frame_count, err_flags and both position counters, and forces IDLE; crc_last is retained.
REQ-020 If clear and a beat arrive on the same cycle, clear wins and the beat is dropped.
REQ-021 cfg_* inputs are sampled live; changing them mid-frame is legal, and checks use the current value.

Reset
REQ-022 rst high on a rising edge sets all of the following, regardless of any in-progress frame:
- crc_last = 0
- crc_valid = 0
- frame_count = 0
- line_count = 0
- pixel_in_line = 0
- err_flags = 0
- irq = 0
- state = IDLE
- internal CRCs = 0xFFFFFFFF
REQ-023 The first frame observed after reset is ignored until a tuser=1 beat arrives.

Verification
REQ-024 Known-answer vector: NUM_CH=3, CH_W=8, cfg_width=9, cfg_height=1. Send 9 beats; channel 0 carries ASCII "123456789" ('1'=0x31 first) with tuser on beat 0 and tlast on beat 8; channels 1 and 2 carry 0. Required: crc_last[31:0]=0xCBF43926, crc_valid and irq pulse once, frame_count=1.
REQ-025 Stability: cfg 4x2, the same pattern sent twice with tvalid toggled randomly and tready held 1. Required: identical crc_last both times, frame_count=2, err_flags=0.
REQ-026 Line errors: cfg 4x2. Line 0 has tlast on beat 2, giving err_flags=0x1; line 1 has 5 beats with no tlast until beat 4, giving err_flags=0x3. Each new flag pulses irq.
REQ-027 Golden compare: frame from REQ-024 with cfg_golden_en=1 and cfg_golden[31:0]=0xCBF43926, other channels programmed correctly, gives err_flags[3]=0. Repeat with 0xCBF43927: err_flags[3]=1 in the same cycle as crc_valid.
REQ-028 Early SOF, reset and clear:
- A tuser beat at line 1, pixel 2 gives err_flags[2]=1, line_count=0, pixel_in_line=1 and crc_last unchanged.
- rst asserted mid-frame returns all outputs to the REQ-022 values.
- A clear pulse together with a valid beat drops that beat.

Source files
------------

// File: rtl/video_stream_crc_monitor.sv
// video_stream_crc_monitor: per-channel CRC-32, geometry checks and golden compare on a passively observed video stream
module video_stream_crc_monitor #(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 8,
  parameter int DIM_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*CH_W-1:0]   s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tready,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  input  logic [DIM_W-1:0]         cfg_width,
  input  logic [DIM_W-1:0]         cfg_height,
  input  logic [NUM_CH*32-1:0]     cfg_golden,
  input  logic                     cfg_golden_en,
  input  logic                     clear,
  output logic [NUM_CH*32-1:0]     crc_last,
  output logic                     crc_valid,
  output logic [31:0]              frame_count,
  output logic [DIM_W-1:0]         line_count,
  output logic [DIM_W-1:0]         pixel_in_line,
  output logic [3:0]               err_flags,
  output logic                     irq
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [NUM_CH-1:0][31:0] crc_q, crc_fold;
  logic [NUM_CH*32-1:0] crc_fin;
  logic [DIM_W-1:0] pix, lin;
  logic [DIM_W:0] pix_inc, lin_inc;
  logic fire, sof, take, short_line, long_line, done, mism;
  logic [3:0] err_nxt;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [CH_W-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < CH_W; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  // clear takes priority over any beat on the same cycle
  assign fire = s_axis_tvalid & s_axis_tready & ~clear;
  assign sof  = fire & s_axis_tuser;
  assign take = fire & (s_axis_tuser | (state == ACTIVE));

  // a start-of-frame beat is always processed as pixel (0,0)
  assign pix     = sof ? '0 : pixel_in_line;
  assign lin     = sof ? '0 : line_count;
  assign pix_inc = {1'b0, pix} + (DIM_W+1)'(1);
  assign lin_inc = {1'b0, lin} + (DIM_W+1)'(1);

  assign short_line = take & s_axis_tlast & (pix_inc < {1'b0, cfg_width});
  assign long_line  = take & ~s_axis_tlast & (pix_inc >= {1'b0, cfg_width});
  assign done       = take & s_axis_tlast & (lin_inc >= {1'b0, cfg_height});

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign crc_fold[k] = crc_step(sof ? '1 : crc_q[k], s_axis_tdata[k*CH_W +: CH_W]);
  end

  assign crc_fin = ~crc_fold;
  assign mism    = cfg_golden_en & (crc_fin != cfg_golden);

  always_comb begin
    state_nxt = clear ? IDLE : take ? (done ? IDLE : ACTIVE) : state;
    err_nxt   = clear ? 4'b0 : err_flags | {done & mism, sof & (state == ACTIVE), long_line, short_line};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      crc_q         <= '1;
      crc_last      <= '0;
      crc_valid     <= 1'b0;
      frame_count   <= '0;
      line_count    <= '0;
      pixel_in_line <= '0;
      err_flags     <= '0;
      irq           <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_flags <= err_nxt;
      crc_valid <= done;
      irq       <= done | |(err_nxt & ~err_flags);
      if (clear) begin
        frame_count   <= '0;
        line_count    <= '0;
        pixel_in_line <= '0;
      end else if (take) begin
        crc_q <= crc_fold;
        if (done) begin
          crc_last      <= crc_fin;
          frame_count   <= frame_count + 32'd1;
          line_count    <= '0;
          pixel_in_line <= '0;
        end else if (s_axis_tlast) begin
          line_count    <= lin_inc[DIM_W-1:0];
          pixel_in_line <= '0;
        end else begin
          line_count    <= lin;
          pixel_in_line <= (&pix) ? pix : pix_inc[DIM_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_video_stream_crc_monitor.sv
// tb_video_stream_crc_monitor: randomized self-checking bench against a frame-level reference model
module tb_video_stream_crc_monitor;
  localparam int NUM_CH = 3, CH_W = 8, DIM_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast, cfg_golden_en, clear;
  logic [23:0] s_axis_tdata;
  logic [15:0] cfg_width, cfg_height, line_count, pixel_in_line;
  logic [95:0] cfg_golden, crc_last;
  logic crc_valid, irq;
  logic [31:0] frame_count;
  logic [3:0] err_flags;

  video_stream_crc_monitor #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_golden(cfg_golden),
    .cfg_golden_en(cfg_golden_en), .clear(clear),
    .crc_last(crc_last), .crc_valid(crc_valid), .frame_count(frame_count),
    .line_count(line_count), .pixel_in_line(pixel_in_line), .err_flags(err_flags), .irq(irq)
  );

  int n_pass = 0, n_total = 0;

  // reference model: frame contents kept as a list of beats, CRC computed byte-wise by table at frame end
  logic [31:0] tbl [256];
  logic [23:0] beats [$];
  bit m_active, m_valid, m_irq;
  int m_px, m_ln;
  logic [3:0] m_err;
  logic [31:0] m_fc;
  logic [95:0] m_crc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit rb(input int n);
    return ($urandom % n) == 0;
  endfunction

  function automatic logic [95:0] model_crc();
    logic [95:0] r;
    logic [31:0] c;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = 32'hFFFFFFFF;
      foreach (beats[i]) c = tbl[c[7:0] ^ beats[i][k*8 +: 8]] ^ (c >> 8);
      r[k*32 +: 32] = ~c;
    end
    return r;
  endfunction

  task automatic compare_all();
    check("crc_last", crc_last, m_crc);
    check("crc_valid", crc_valid, m_valid);
    check("frame_count", frame_count, m_fc);
    check("line_count", line_count, 16'(m_ln));
    check("pixel_in_line", pixel_in_line, 16'(m_px));
    check("err_flags", err_flags, m_err);
    check("irq", irq, m_irq);
  endtask

  task automatic step(input logic [23:0] d, input bit v, input bit r, input bit u, input bit l, input bit c);
    logic [3:0] ne;
    s_axis_tdata = d; s_axis_tvalid = v; s_axis_tready = r;
    s_axis_tuser = u; s_axis_tlast = l; clear = c;
    m_valid = 0; m_irq = 0; ne = '0;
    if (c) begin
      m_fc = '0; m_err = '0; m_px = 0; m_ln = 0; m_active = 0;
    end else if (v && r && (m_active || u)) begin
      if (u) begin
        if (m_active) ne[2] = 1'b1;
        m_px = 0; m_ln = 0; m_active = 1; beats.delete();
      end
      beats.push_back(d);
      if (l && m_px + 1 < int'(cfg_width)) ne[0] = 1'b1;
      if (!l && m_px + 1 >= int'(cfg_width)) ne[1] = 1'b1;
      if (l) begin
        if (m_ln + 1 >= int'(cfg_height)) begin
          m_crc = model_crc(); m_valid = 1; m_fc = m_fc + 1; m_active = 0; m_ln = 0;
          if (cfg_golden_en && m_crc != cfg_golden) ne[3] = 1'b1;
        end else m_ln++;
        m_px = 0;
      end else if (m_px < 65535) m_px++;
      m_irq = m_valid || ((ne & ~m_err) != 0);
      m_err |= ne;
    end
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle();
    step(24'($urandom), 0, 1, rb(2), rb(2), 0);
  endtask

  task automatic do_reset();
    rst = 1; s_axis_tvalid = 1; s_axis_tready = 1; clear = 0;
    @(posedge clk); #1;
    rst = 0;
    m_active = 0; m_valid = 0; m_irq = 0; m_px = 0; m_ln = 0;
    m_err = '0; m_fc = '0; m_crc = '0; beats.delete();
    compare_all();
  endtask

  task automatic send_kat();
    string s;
    s = "123456789";
    for (int i = 0; i < 9; i++) step({16'h0, s[i]}, 1, 1, i == 0, i == 8, 0);
  endtask

  logic [23:0] pat [8];
  logic [95:0] saved;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[i] = c;
    end
    s_axis_tdata = '0; s_axis_tuser = 0; s_axis_tlast = 0;
    cfg_width = 16'd9; cfg_height = 16'd1; cfg_golden = '0; cfg_golden_en = 0;
    do_reset();

    // beats before any start-of-frame are ignored
    for (int i = 0; i < 3; i++) step(24'($urandom), 1, 1, 0, rb(2), 0);

    send_kat();
    check("kat_crc", crc_last[31:0], 32'hCBF43926);
    check("kat_valid", crc_valid, 1'b1);
    check("kat_frames", frame_count, 32'd1);
    idle();
    check("kat_valid_drop", crc_valid, 1'b0);

    cfg_golden = {m_crc[95:32], 32'hCBF43926}; cfg_golden_en = 1;
    send_kat();
    check("gold_ok", err_flags[3], 1'b0);
    cfg_golden[31:0] = 32'hCBF43927;
    send_kat();
    check("gold_bad_err", err_flags[3], 1'b1);
    check("gold_bad_valid", crc_valid, 1'b1);
    cfg_golden_en = 0;
    idle();

    step(24'($urandom), 1, 1, 1, 0, 1);
    check("clear_drop_pix", pixel_in_line, 16'd0);
    check("clear_err", err_flags, 4'd0);
    step(24'($urandom), 1, 1, 0, 0, 0);
    check("clear_idle_pix", pixel_in_line, 16'd0);

    cfg_width = 16'd4; cfg_height = 16'd2;
    for (int i = 0; i < 8; i++) pat[i] = 24'($urandom);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 8; i++) begin
        while (rb(2)) idle();
        step(pat[i], 1, 1, i == 0, i == 3 || i == 7, 0);
      end
      if (rep == 0) saved = m_crc;
    end
    check("stab_crc", crc_last, saved);
    check("stab_frames", frame_count, 32'd2);
    check("stab_err", err_flags, 4'd0);

    step('0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(24'($urandom), 1, 1, i == 0, i == 2, 0);
    check("short_err", err_flags, 4'h1);
    check("short_irq", irq, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(24'($urandom), 1, 1, 0, i == 4, 0);
      if (i == 3) begin
        check("long_err", err_flags, 4'h3);
        check("long_irq", irq, 1'b1);
      end
    end

    step('0, 0, 1, 0, 0, 1);
    cfg_height = 16'd3;
    saved = m_crc;
    for (int i = 0; i < 4; i++) step(24'($urandom), 1, 1, i == 0, i == 3, 0);
    for (int i = 0; i < 2; i++) step(24'($urandom), 1, 1, 0, 0, 0);
    step(24'($urandom), 1, 1, 1, 0, 0);
    check("sof_err", err_flags[2], 1'b1);
    check("sof_line", line_count, 16'd0);
    check("sof_pix", pixel_in_line, 16'd1);
    check("sof_crc", crc_last, saved);

    // random traffic with handshake gaps, clears and golden mismatches
    step('0, 0, 1, 0, 0, 1);
    cfg_width = 16'd3; cfg_height = 16'd2; cfg_golden = '0;
    for (int i = 0; i < 400; i++) begin
      cfg_golden_en = (i > 200);
      step(24'($urandom), rb(2) || rb(2), !rb(4), rb(12), rb(3), rb(60));
    end

    cfg_width = 16'd4; cfg_height = 16'd2; cfg_golden_en = 0;
    for (int i = 0; i < 5; i++) step(24'($urandom), 1, 1, i == 0, i == 3, 0);
    do_reset();
    check("rst_crc", crc_last, 96'd0);
    check("rst_frames", frame_count, 32'd0);
    for (int i = 0; i < 4; i++) step(24'($urandom), 1, 1, 0, i == 3, 0);
    check("rst_ignore", pixel_in_line, 16'd0);
    cfg_width = 16'd9; cfg_height = 16'd1;
    send_kat();
    check("rst_kat_crc", crc_last[31:0], 32'hCBF43926);
    check("rst_kat_frames", frame_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
